alu_operand_sequencer: RTL and testbench

//  Upstream front end of the 4-bit ALU lab datapath. Debounces two push buttons and walks an FSM

---
 rtl/alu_operand_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Front end for the 4-bit ALU lab: debounces enter/clear and walks LOAD_A -> LOAD_B -> LOAD_OP -> EXEC -> SHOW,
// holding operands on the ALU and capturing its result one cycle after the opcode is loaded.

module alu_seq_debounce #(
   parameter int DB_CYCLES = 1000000,
   parameter int CNT_W     = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic press_o
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             meta_q, sync_q, stable_q, press_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         stable_q <= 1'b0;
         press_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         meta_q  <= btn_i;
         sync_q  <= meta_q;
         press_q <= 1'b0;
         if (sync_q == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            // Accept the new level; only a rising acceptance is a press.
            stable_q <= sync_q;
            cnt_q    <= '0;
            press_q  <= sync_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign press_o = press_q;
endmodule

module alu_operand_sequencer #(
   parameter int DB_CYCLES = 1000000,
   parameter int CNT_W     = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw_data,
   input  logic [2:0] sw_op,
   input  logic       btn_enter,
   input  logic       btn_clr,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [3:0] alu_result,
   input  logic [2:0] alu_flags,
   output logic [3:0] res_q,
   output logic [2:0] flags_q,
   output logic       res_valid,
   output logic       done,
   output logic [4:0] stage
);
   typedef enum logic [2:0] {S_LOAD_A, S_LOAD_B, S_LOAD_OP, S_EXEC, S_SHOW} state_t;

   logic [1:0] btn_raw, press;
   logic       enter_evt, clr_evt;

   assign btn_raw = {btn_clr, btn_enter};

   for (genvar i = 0; i < 2; i++) begin : g_db
      alu_seq_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
         .clk    (clk),
         .rst_n  (rst_n),
         .btn_i  (btn_raw[i]),
         .press_o(press[i])
      );
   end

   assign enter_evt = press[0];
   assign clr_evt   = press[1];

   state_t     state_q, state_d;
   logic [3:0] a_q, a_d, b_q, b_d, res_d;
   logic [2:0] op_q, op_d, flags_d;
   logic       done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_LOAD_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         flags_q <= flags_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      flags_d = flags_q;
      done_d  = 1'b0;
      if (clr_evt) begin
         state_d = S_LOAD_A;
         a_d     = '0;
         b_d     = '0;
         op_d    = '0;
         res_d   = '0;
         flags_d = '0;
      end else begin
         unique case (state_q)
            S_LOAD_A:  if (enter_evt) begin a_d  = sw_data; state_d = S_LOAD_B;  end
            S_LOAD_B:  if (enter_evt) begin b_d  = sw_data; state_d = S_LOAD_OP; end
            S_LOAD_OP: if (enter_evt) begin op_d = sw_op;   state_d = S_EXEC;    end
            S_EXEC: begin
               // ALU inputs have been stable for a full cycle; enter here is ignored.
               res_d   = alu_result;
               flags_d = alu_flags;
               done_d  = 1'b1;
               state_d = S_SHOW;
            end
            S_SHOW:    if (enter_evt) state_d = S_LOAD_A;
            default:   state_d = S_LOAD_A;
         endcase
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;
   assign done      = done_q;
   assign res_valid = (state_q == S_SHOW);
   assign stage     = 5'(1) << state_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized bench for alu_operand_sequencer against a cycle-level behavioural model with a toy ALU.

module tb_alu_operand_sequencer;
   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] sw_data = '0;
   logic [2:0] sw_op = '0;
   logic       btn_enter = 1'b0, btn_clr = 1'b0;
   logic [3:0] alu_a, alu_b, alu_result, res_q;
   logic [2:0] alu_op, alu_flags, flags_q;
   logic       res_valid, done;
   logic [4:0] stage;

   int n_chk = 0, n_fail = 0, done_cnt = 0;

   always #5 clk = ~clk;

   alu_operand_sequencer #(.DB_CYCLES(DB), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .sw_data(sw_data), .sw_op(sw_op),
      .btn_enter(btn_enter), .btn_clr(btn_clr),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .res_q(res_q), .flags_q(flags_q), .res_valid(res_valid), .done(done), .stage(stage)
   );

   // Toy ALU: returns {carry, zero, overflow, result}.
   function automatic logic [6:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      logic [4:0] s;
      logic [3:0] r;
      logic       c, v;
      c = 1'b0; v = 1'b0; s = '0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
         3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         default: r = a;
      endcase
      return {c, (r == 4'h0), v, r};
   endfunction

   assign {alu_flags, alu_result} = alu_f(alu_a, alu_b, alu_op);

   // Behavioural model: buttons seen through a two-cycle delay, accepted after DB consecutive differing cycles.
   logic [1:0] m_sync1, m_sync2, m_stab, m_ev, nev;
   int         m_run [2];
   int         m_state;
   logic [3:0] m_a, m_b, m_res;
   logic [2:0] m_op, m_flags;
   logic       m_done;

   task automatic model_reset();
      m_sync1 = '0; m_sync2 = '0; m_stab = '0; m_ev = '0;
      m_run[0] = 0; m_run[1] = 0;
      m_state = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flags = '0; m_done = 1'b0;
   endtask

   task automatic model_step();
      m_done = 1'b0;
      if (m_ev[1]) begin
         m_state = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flags = '0;
      end else begin
         case (m_state)
            0: if (m_ev[0]) begin m_a = sw_data; m_state = 1; end
            1: if (m_ev[0]) begin m_b = sw_data; m_state = 2; end
            2: if (m_ev[0]) begin m_op = sw_op; m_state = 3; end
            3: begin {m_flags, m_res} = alu_f(m_a, m_b, m_op); m_done = 1'b1; m_state = 4; end
            default: if (m_ev[0]) m_state = 0;
         endcase
      end
      for (int i = 0; i < 2; i++) begin
         nev[i] = 1'b0;
         if (m_sync2[i] != m_stab[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DB) begin
               m_stab[i] = m_sync2[i];
               m_run[i]  = 0;
               nev[i]    = m_stab[i];
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_sync2 = m_sync1;
      m_sync1 = {btn_clr, btn_enter};
      m_ev    = nev;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   always @(negedge clk) begin
      logic [24:0] act, exp;
      act = {alu_a, alu_b, alu_op, res_q, flags_q, res_valid, done, stage};
      exp = {m_a, m_b, m_op, m_res, m_flags, (m_state == 4), m_done, 5'(1 << m_state)};
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL model_cmp t=%0t: got %h expected %h", $time, act, exp);
      end
      if (done) done_cnt++;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic press(input logic e, input logic c, input int hold, input int idle);
      btn_enter = e; btn_clr = c;
      cycles(hold);
      btn_enter = 1'b0; btn_clr = 1'b0;
      cycles(idle);
   endtask

   initial begin
      cycles(3);
      chk("reset_stage", stage, 5'b00001);
      chk("reset_outs", {alu_a, alu_b, alu_op, res_q, flags_q, res_valid, done}, 0);
      rst_n = 1'b1;
      cycles(2);

      // 1: long hold gives one event
      sw_data = 4'h5;
      press(1'b1, 1'b0, 10, 12);
      chk("t1_stage", stage, 5'b00010);
      chk("t1_alu_a", alu_a, 4'h5);

      // 2: short glitch ignored
      sw_data = 4'h9;
      press(1'b1, 1'b0, 2, 12);
      chk("t2_stage", stage, 5'b00010);

      // 3: full operation 7 + 1
      press(1'b0, 1'b1, 6, 12);
      chk("t3_clr_stage", stage, 5'b00001);
      sw_data = 4'h7; press(1'b1, 1'b0, 6, 12);
      sw_data = 4'h1; press(1'b1, 1'b0, 6, 12);
      done_cnt = 0;
      sw_op = 3'b000; press(1'b1, 1'b0, 6, 12);
      chk("t3_done_pulses", done_cnt, 1);
      chk("t3_res", res_q, 4'h8);
      chk("t3_flags", flags_q, 3'b001);
      chk("t3_valid", res_valid, 1);
      chk("t3_stage", stage, 5'b10000);

      // 4: SHOW -> LOAD_A keeps values
      sw_data = 4'hc; sw_op = 3'b101;
      press(1'b1, 1'b0, 6, 12);
      chk("t4_stage", stage, 5'b00001);
      chk("t4_vals", {alu_a, alu_b, alu_op, res_q}, {4'h7, 4'h1, 3'b000, 4'h8});

      // 5: simultaneous enter + clear in LOAD_OP
      sw_data = 4'h3; press(1'b1, 1'b0, 6, 12);
      sw_data = 4'h2; press(1'b1, 1'b0, 6, 12);
      chk("t5_pre_stage", stage, 5'b00100);
      press(1'b1, 1'b1, 6, 12);
      chk("t5_stage", stage, 5'b00001);
      chk("t5_outs", {alu_a, alu_b, alu_op, res_q, flags_q, res_valid, done}, 0);

      // 6: reset mid-debounce with button held through release
      sw_data = 4'ha; press(1'b1, 1'b0, 6, 12);
      chk("t6_pre_stage", stage, 5'b00010);
      btn_enter = 1'b1;
      cycles(3);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_stage", stage, 5'b00001);
      chk("t6_rst_a", alu_a, 0);
      cycles(2);
      rst_n = 1'b1;
      cycles(12);
      chk("t6_stage", stage, 5'b00010);
      chk("t6_a", alu_a, 4'ha);
      btn_enter = 1'b0;
      cycles(12);

      // Random traffic against the model
      for (int it = 0; it < 250; it++) begin
         int r;
         sw_data = 4'($urandom);
         sw_op   = 3'($urandom);
         r = $urandom_range(0, 11);
         case (r)
            0:       press(1'b1, 1'b0, $urandom_range(1, 3), $urandom_range(0, 10));
            1:       press(1'b0, 1'b1, $urandom_range(4, 8), $urandom_range(0, 10));
            2:       press(1'b1, 1'b1, $urandom_range(3, 6), $urandom_range(0, 10));
            3:       press(1'b0, 1'b1, $urandom_range(1, 3), $urandom_range(0, 10));
            default: press(1'b1, 1'b0, $urandom_range(4, 8), $urandom_range(0, 10));
         endcase
      end
      cycles(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
